// File: rtl/ibex_icache_inval_ctrl.sv
// ibex_icache_inval_ctrl
// Sequences an invalidate-all of the instruction cache tag RAMs. After reset,
// and on each invalidate request, the block optionally fetches a fresh
// scramble key/nonce from the key manager and then writes zero to every tag
// line, one line per cycle, across all ways. While it is busy, cache lookups
// are blocked from the tag RAM.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   icache_inval_i                     invalidate-all request pulse
//   scramble_key_valid_i/_key_i/_nonce_i  key manager response
//   scramble_key_req_o                 key request to the key manager
//   scramble_key_valid_q/_key_q/_nonce_q  registered key state to the RAMs
//   lookup_req_i / lookup_gnt_o        tag RAM arbitration for lookups/fills
//   inval_tag_req_o/_write_o/_addr_o/_wdata_o  tag RAM sweep port
//   busy_o                             key handshake or sweep in progress
module ibex_icache_inval_ctrl #(
    parameter bit          ICacheScramble   = 1'b0,
    parameter int unsigned IC_NUM_WAYS      = 2,
    parameter int unsigned IC_NUM_LINES     = 256,
    parameter int unsigned IC_INDEX_W       = $clog2(IC_NUM_LINES),
    parameter int unsigned IC_TAG_SIZE      = 22,
    parameter int unsigned TagSizeECC       = IC_TAG_SIZE,
    parameter int unsigned SCRAMBLE_KEY_W   = 128,
    parameter int unsigned SCRAMBLE_NONCE_W = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        icache_inval_i,
    input  logic                        scramble_key_valid_i,
    input  logic [SCRAMBLE_KEY_W-1:0]   scramble_key_i,
    input  logic [SCRAMBLE_NONCE_W-1:0] scramble_nonce_i,
    output logic                        scramble_key_req_o,
    output logic                        scramble_key_valid_q,
    output logic [SCRAMBLE_KEY_W-1:0]   scramble_key_q,
    output logic [SCRAMBLE_NONCE_W-1:0] scramble_nonce_q,
    input  logic                        lookup_req_i,
    output logic                        lookup_gnt_o,
    output logic [IC_NUM_WAYS-1:0]      inval_tag_req_o,
    output logic                        inval_tag_write_o,
    output logic [IC_INDEX_W-1:0]       inval_tag_addr_o,
    output logic [TagSizeECC-1:0]       inval_tag_wdata_o,
    output logic                        busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        KEY_REQ = 2'd1,
        INVAL   = 2'd2
    } state_e;

    localparam logic [IC_INDEX_W-1:0] LAST_IDX = IC_INDEX_W'(IC_NUM_LINES - 1);

    // Every sequence begins either with the key handshake or directly with the sweep.
    localparam state_e START_STATE = ICacheScramble ? KEY_REQ : INVAL;

    state_e                state_r;
    state_e                state_next_s;
    logic                  boot_r;        // forces one sequence right after reset release
    logic                  pending_r;
    logic                  pending_next_s;
    logic [IC_INDEX_W-1:0] cnt_r;
    logic [IC_INDEX_W-1:0] cnt_next_s;
    logic                  busy_s;
    logic                  last_s;

    assign busy_s = (state_r != IDLE);
    assign last_s = (state_r == INVAL) && (cnt_r == LAST_IDX);

    // State, boot flag, pending flag and line counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            boot_r    <= 1'b1;
            pending_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            state_r   <= state_next_s;
            boot_r    <= 1'b0;
            pending_r <= pending_next_s;
            cnt_r     <= cnt_next_s;
        end
    end

    // Next-state decode; a pending or same-cycle request chains straight into
    // the next sequence without passing through IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (boot_r || icache_inval_i) begin
                    state_next_s = START_STATE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            KEY_REQ: begin
                if (scramble_key_valid_i) begin
                    state_next_s = INVAL;
                end else begin
                    state_next_s = KEY_REQ;
                end
            end
            INVAL: begin
                if (last_s) begin
                    if (pending_r || icache_inval_i) begin
                        state_next_s = START_STATE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = INVAL;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Pending flag: requests while busy merge into one flag, consumed at sweep end.
    // A request landing in the last sweep cycle is consumed directly above.
    always_comb begin
        pending_next_s = pending_r;
        if (last_s) begin
            pending_next_s = 1'b0;
        end else if (busy_s && icache_inval_i) begin
            pending_next_s = 1'b1;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Line counter: advances only while sweeping and sits at zero otherwise.
    always_comb begin
        cnt_next_s = '0;
        if ((state_r == INVAL) && !last_s) begin
            cnt_next_s = cnt_r + IC_INDEX_W'(1);
        end else begin
            cnt_next_s = '0;
        end
    end

    // Output decode from the registered state and counter.
    always_comb begin
        inval_tag_req_o    = '0;
        inval_tag_write_o  = 1'b0;
        inval_tag_addr_o   = '0;
        inval_tag_wdata_o  = '0;
        scramble_key_req_o = 1'b0;
        if (state_r == INVAL) begin
            inval_tag_req_o   = '1;
            inval_tag_write_o = 1'b1;
            inval_tag_addr_o  = cnt_r;
        end else begin
            scramble_key_req_o = (state_r == KEY_REQ);
        end
    end

    assign busy_o = busy_s;
    // Gated with reset so that no grant escapes while the block is held in reset.
    assign lookup_gnt_o = lookup_req_i & ~busy_s & rst_ni;

    if (ICacheScramble) begin : g_scramble
        logic                        key_valid_r;
        logic [SCRAMBLE_KEY_W-1:0]   key_r;
        logic [SCRAMBLE_NONCE_W-1:0] nonce_r;
        logic                        key_capture_s;
        logic                        key_enter_s;

        assign key_capture_s = (state_r == KEY_REQ) && scramble_key_valid_i;
        // Old key is invalidated as soon as a new handshake starts.
        assign key_enter_s   = (state_r != KEY_REQ) && (state_next_s == KEY_REQ);

        // Key/nonce capture; the key inputs are only looked at during KEY_REQ.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                key_valid_r <= 1'b0;
                key_r       <= '0;
                nonce_r     <= '0;
            end else if (key_capture_s) begin
                key_valid_r <= 1'b1;
                key_r       <= scramble_key_i;
                nonce_r     <= scramble_nonce_i;
            end else if (key_enter_s) begin
                key_valid_r <= 1'b0;
            end else begin
                key_valid_r <= key_valid_r;
            end
        end

        assign scramble_key_valid_q = key_valid_r;
        assign scramble_key_q       = key_r;
        assign scramble_nonce_q     = nonce_r;
    end else begin : g_no_scramble
        logic unused_key_s;
        assign unused_key_s         = ^{scramble_key_i, scramble_nonce_i};
        assign scramble_key_valid_q = 1'b0;
        assign scramble_key_q       = '0;
        assign scramble_nonce_q     = '0;
    end

endmodule

// File: tb/tb_ibex_icache_inval_ctrl.sv
module tb_ibex_icache_inval_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: no scrambling
    logic          rst_n0, inval0, kv0, lreq0;
    logic [127:0]  key0;
    logic [63:0]   nonce0;
    logic          kreq0, kvq0, gnt0, twr0, busy0;
    logic [127:0]  keyq0;
    logic [63:0]   nonceq0;
    logic [1:0]    treq0;
    logic [7:0]    taddr0;
    logic [21:0]   twd0;

    // DUT 1: scrambling enabled
    logic          rst_n1, inval1, kv1, lreq1;
    logic [127:0]  key1;
    logic [63:0]   nonce1;
    logic          kreq1, kvq1, gnt1, twr1, busy1;
    logic [127:0]  keyq1;
    logic [63:0]   nonceq1;
    logic [1:0]    treq1;
    logic [7:0]    taddr1;
    logic [21:0]   twd1;

    ibex_icache_inval_ctrl #(.ICacheScramble(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n0), .icache_inval_i(inval0),
        .scramble_key_valid_i(kv0), .scramble_key_i(key0), .scramble_nonce_i(nonce0),
        .scramble_key_req_o(kreq0), .scramble_key_valid_q(kvq0),
        .scramble_key_q(keyq0), .scramble_nonce_q(nonceq0),
        .lookup_req_i(lreq0), .lookup_gnt_o(gnt0),
        .inval_tag_req_o(treq0), .inval_tag_write_o(twr0),
        .inval_tag_addr_o(taddr0), .inval_tag_wdata_o(twd0), .busy_o(busy0)
    );

    ibex_icache_inval_ctrl #(.ICacheScramble(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n1), .icache_inval_i(inval1),
        .scramble_key_valid_i(kv1), .scramble_key_i(key1), .scramble_nonce_i(nonce1),
        .scramble_key_req_o(kreq1), .scramble_key_valid_q(kvq1),
        .scramble_key_q(keyq1), .scramble_nonce_q(nonceq1),
        .lookup_req_i(lreq1), .lookup_gnt_o(gnt1),
        .inval_tag_req_o(treq1), .inval_tag_write_o(twr1),
        .inval_tag_addr_o(taddr1), .inval_tag_wdata_o(twd1), .busy_o(busy1)
    );

    typedef struct {
        logic       inval;
        logic       lreq;
        logic       kv;
        logic       e_busy;
        logic       e_wr;
        logic [7:0] e_addr;
        logic       e_gnt;
    } vec_t;

    vec_t vq[$];
    int   vectors    = 0;
    int   miscompares = 0;

    localparam logic [127:0] KEY_A5   = {16{8'hA5}};
    localparam logic [127:0] KEY_5A   = {16{8'h5A}};
    localparam logic [127:0] KEY_33   = {16{8'h33}};
    localparam logic [63:0]  NONCE_3C = {8{8'h3C}};

    task automatic add(input logic inval, input logic lreq, input logic kv,
                       input logic busy, input logic wr, input logic [7:0] addr,
                       input logic gnt);
        vec_t v;
        v.inval = inval; v.lreq = lreq; v.kv = kv;
        v.e_busy = busy; v.e_wr = wr; v.e_addr = addr; v.e_gnt = gnt;
        vq.push_back(v);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n0 = 1'b0; inval0 = 1'b0; kv0 = 1'b0; lreq0 = 1'b0;
        key0 = {4{32'hDEADBEEF}}; nonce0 = {2{32'hCAFEF00D}};
        rst_n1 = 1'b0; inval1 = 1'b0; kv1 = 1'b0; lreq1 = 1'b0;
        key1 = '0; nonce1 = '0;

        // Vector table for DUT 0; vector k is the k-th cycle after reset release.
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);               // boot cycle in IDLE
        for (int k = 0; k < 256; k++)                               // post-reset sweep
            add(1'b0, 1'b1, (k == 10), 1'b1, 1'b1, 8'(k), 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);               // first IDLE: grant
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);               // request from IDLE
        for (int k = 0; k < 256; k++)                               // sweep A, requests at 100 and 200 merge
            add((k == 100) || (k == 200), k[0], 1'b0, 1'b1, 1'b1, 8'(k), 1'b0);
        for (int k = 0; k < 256; k++)                               // sweep B back-to-back, request in last cycle
            add((k == 255), 1'b0, 1'b0, 1'b1, 1'b1, 8'(k), 1'b0);
        for (int k = 0; k < 256; k++)                               // sweep C
            add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'(k), 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);               // back to IDLE, exactly one extra sweep
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

        // Reset state of both DUTs.
        lreq0 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk1("rst0_busy", busy0, 1'b0);
        chk1("rst0_gnt", gnt0, 1'b0);
        chk1("rst0_wr", twr0, 1'b0);
        chkw("rst0_addr", 128'(taddr0), 128'd0);
        chk1("rst1_kreq", kreq1, 1'b0);
        chk1("rst1_kvq", kvq1, 1'b0);
        chkw("rst1_key", keyq1, 128'd0);

        // Table-driven run of DUT 0.
        @(negedge clk);
        rst_n0 = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            inval0 = vq[i].inval; lreq0 = vq[i].lreq; kv0 = vq[i].kv;
            #1;
            vectors++;
            if (busy0 !== vq[i].e_busy || gnt0 !== vq[i].e_gnt || twr0 !== vq[i].e_wr ||
                taddr0 !== vq[i].e_addr || treq0 !== {2{vq[i].e_wr}} || twd0 !== 22'd0 ||
                kreq0 !== 1'b0 || kvq0 !== 1'b0 || keyq0 !== 128'd0 || nonceq0 !== 64'd0) begin
                miscompares++;
                $display("FAIL vec%0d: got busy=%b gnt=%b wr=%b addr=%0d treq=%b wdata=%h kreq=%b kvq=%b key=%h nonce=%h expected busy=%b gnt=%b wr=%b addr=%0d treq=%b and zero key outputs",
                         i, busy0, gnt0, twr0, taddr0, treq0, twd0, kreq0, kvq0, keyq0, nonceq0,
                         vq[i].e_busy, vq[i].e_gnt, vq[i].e_wr, vq[i].e_addr, {2{vq[i].e_wr}});
            end
            @(negedge clk);
        end
        inval0 = 1'b0; kv0 = 1'b0;

        // Reset in the middle of a sweep at index 37, then restart from 0.
        rst_n0 = 1'b0;
        @(negedge clk);
        rst_n0 = 1'b1;
        repeat (38) @(negedge clk);
        #1;
        chkw("mid_addr37", 128'(taddr0), 128'd37);
        chk1("mid_wr", twr0, 1'b1);
        lreq0 = 1'b1;
        rst_n0 = 1'b0;
        #1;
        chk1("rstmid_wr", twr0, 1'b0);
        chkw("rstmid_addr", 128'(taddr0), 128'd0);
        chkw("rstmid_treq", 128'(treq0), 128'd0);
        chk1("rstmid_busy", busy0, 1'b0);
        chk1("rstmid_gnt", gnt0, 1'b0);
        @(negedge clk);
        rst_n0 = 1'b1;
        #1;
        chk1("rel_boot_busy", busy0, 1'b0);
        @(negedge clk); #1;
        chk1("rel_wr", twr0, 1'b1);
        chkw("rel_addr0", 128'(taddr0), 128'd0);
        @(negedge clk); #1;
        chkw("rel_addr1", 128'(taddr0), 128'd1);

        // DUT 1: key handshake after reset; a key offered in IDLE is ignored.
        @(negedge clk);
        rst_n1 = 1'b1;
        kv1 = 1'b1; key1 = KEY_33; nonce1 = 64'd7;
        #1;
        chk1("s_c0_kreq", kreq1, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            kv1 = (c == 5);
            key1 = (c == 5) ? KEY_A5 : KEY_33;
            nonce1 = NONCE_3C;
            #1;
            chk1($sformatf("s_c%0d_kreq", c), kreq1, 1'b1);
            chk1($sformatf("s_c%0d_kvq", c), kvq1, 1'b0);
            chk1($sformatf("s_c%0d_busy", c), busy1, 1'b1);
            chk1($sformatf("s_c%0d_wr", c), twr1, 1'b0);
        end
        chkw("s_key_before", keyq1, 128'd0);
        @(negedge clk);
        kv1 = 1'b0; lreq1 = 1'b1;
        #1;
        chk1("s_c6_kreq", kreq1, 1'b0);
        chk1("s_c6_kvq", kvq1, 1'b1);
        chkw("s_c6_key", keyq1, KEY_A5);
        chkw("s_c6_nonce", 128'(nonceq1), 128'(NONCE_3C));
        chk1("s_c6_wr", twr1, 1'b1);
        chkw("s_c6_addr", 128'(taddr1), 128'd0);
        chkw("s_c6_treq", 128'(treq1), 128'd3);
        chkw("s_c6_wdata", 128'(twd1), 128'd0);
        chk1("s_c6_gnt", gnt1, 1'b0);
        repeat (255) @(negedge clk);
        #1;
        chkw("s_last_addr", 128'(taddr1), 128'd255);
        @(negedge clk);
        #1;
        chk1("s_idle_busy", busy1, 1'b0);
        chk1("s_idle_gnt", gnt1, 1'b1);
        // New key offered in IDLE must not be captured.
        kv1 = 1'b1; key1 = KEY_5A;
        @(negedge clk);
        kv1 = 1'b0;
        #1;
        chkw("s_idle_key_kept", keyq1, KEY_A5);
        chk1("s_idle_kvq_kept", kvq1, 1'b1);
        // Invalidate from IDLE restarts the handshake and drops the old key valid.
        inval1 = 1'b1;
        @(negedge clk);
        inval1 = 1'b0;
        #1;
        chk1("s_rereq_kreq", kreq1, 1'b1);
        chk1("s_rereq_kvq", kvq1, 1'b0);
        chk1("s_rereq_busy", busy1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
